gate_sweep_ctrl: RTL

Sequencer that exercises a combinational N-input logic gate on the iCEzum board. On a start request it drives every input combination in ascending order, holds each one for a programmable settle time, and samples the gate output. It assembles a truth-table word and compares it against an expected word to flag pass or fail. It sits between board push-buttons/LEDs and a gate instance such as or2, replacing the hand-written stimulus sequence with self-checking hardware.

---
 rtl/gate_sweep_ctrl_pkg.sv | 13 +
 rtl/gate_sweep_ctrl_if.sv | 26 ++
 rtl/gate_sweep_ctrl_dwell_counter.sv | 37 +++
 rtl/gate_sweep_ctrl.sv | 99 +++++++++
 4 files changed

// File: rtl/gate_sweep_ctrl_pkg.sv
// Shared types and constants for the gate sweep sequencer.
// State encoding is plain binary; the dwell counter width is fixed here.
package gate_sweep_ctrl_pkg;

  localparam int unsigned CntW = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/gate_sweep_ctrl_if.sv
// Bundle between the sweep sequencer and the board side (buttons, LEDs, gate under control).
interface gate_sweep_ctrl_if #(
  parameter int unsigned N_IN = 2
);
  localparam int unsigned NVec = 2 ** N_IN;

  logic            start;
  logic            z0;
  logic [N_IN-1:0] x;
  logic            busy;
  logic            done;
  logic [NVec-1:0] truth_table;
  logic            pass;
  logic            fail;

  modport master (
    input  start, z0,
    output x, busy, done, truth_table, pass, fail
  );

  modport slave (
    output start, z0,
    input  x, busy, done, truth_table, pass, fail
  );

endinterface

// File: rtl/gate_sweep_ctrl_dwell_counter.sv
// 16-bit dwell counter with clear/enable; tc_o flags the last cycle of a dwell period.
module gate_sweep_ctrl_dwell_counter
  import gate_sweep_ctrl_pkg::*;
#(
  parameter int unsigned DWELL = 12
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CntW-1:0] LastCnt = CntW'(DWELL - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == LastCnt);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Drives every input vector of a combinational gate in ascending order, samples z0 at the
// end of each dwell period, and compares the captured truth table with EXPECT.
module gate_sweep_ctrl
  import gate_sweep_ctrl_pkg::*;
#(
  parameter int unsigned         N_IN   = 2,
  parameter int unsigned         DWELL  = 12,
  parameter logic [2**N_IN-1:0]  EXPECT = 4'b1110
) (
  input logic              clk,
  input logic              rstn,
  gate_sweep_ctrl_if.master bus
);

  localparam int unsigned     NVec    = 2 ** N_IN;
  localparam logic [N_IN-1:0] LastIdx = N_IN'(NVec - 1);

  state_e          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [NVec-1:0] tbl_q, tbl_d;
  logic            pass_q, pass_d;
  logic            fail_q, fail_d;
  logic            cnt_clr, cnt_en, tc;

  gate_sweep_ctrl_dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk   (clk),
    .rstn  (rstn),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (tc)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tbl_d   = tbl_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    cnt_en  = 1'b0;
    cnt_clr = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StRun;
          idx_d   = '0;
          tbl_d   = '0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
        end
      end
      StRun: begin
        cnt_en  = 1'b1;
        cnt_clr = tc;
        if (tc) begin
          tbl_d[idx_q] = bus.z0;
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        idx_d   = '0;
        pass_d  = (tbl_q == EXPECT);
        fail_d  = (tbl_q != EXPECT);
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      idx_q   <= '0;
      tbl_q   <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tbl_q   <= tbl_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  // idx_q still holds the last vector during DONE, so mask x outside RUN.
  assign bus.x           = (state_q == StRun) ? idx_q : '0;
  assign bus.busy        = (state_q == StRun);
  assign bus.done        = (state_q == StDone);
  assign bus.truth_table = tbl_q;
  assign bus.pass        = pass_q;
  assign bus.fail        = fail_q;

endmodule
